// File: rtl/gg_pkg.sv
// Shared constants for the Givens-generation (vectoring CORDIC) stage and the
// rotation units that replay its micro-step decisions.
package gg_pkg;

   localparam int R_LEN_DEF    = 12;
   localparam int R_FRAC_DEF   = 2;
   localparam int ITER_CYC_DEF = 3;

   localparam logic [1:0] D_CW   = 2'd0;
   localparam logic [1:0] D_CCW  = 2'd1;
   localparam logic [1:0] D_SKIP = 2'd2;

   typedef enum logic {
      IDLE = 1'b0,
      ROT  = 1'b1
   } state_e;

endpackage

// File: rtl/gg_micro_step.sv
// One vectoring CORDIC micro-rotation: pushes y toward zero by the shift s and
// reports the chosen direction so the rotation units can replay it bit-exactly.
module gg_micro_step
   import gg_pkg::*;
#(
   parameter int W = R_LEN_DEF
) (
   input  logic signed [W-1:0] x_i,
   input  logic signed [W-1:0] y_i,
   input  logic        [3:0]   shift,
   output logic signed [W-1:0] x_o,
   output logic signed [W-1:0] y_o,
   output logic        [1:0]   d_o
);

   // Both updates use the pre-step x and y; shifts floor, adds wrap at W bits.
   always_comb begin
      x_o = x_i;
      y_o = y_i;
      d_o = D_SKIP;
      if (y_i != '0) begin
         if (!y_i[W-1]) begin
            x_o = x_i + (y_i >>> shift);
            y_o = y_i - (x_i >>> shift);
            d_o = D_CW;
         end else begin
            x_o = x_i - (y_i >>> shift);
            y_o = y_i + (x_i >>> shift);
            d_o = D_CCW;
         end
      end
   end

endmodule

// File: rtl/gg_vectoring.sv
// Vectoring-mode CORDIC Givens generator: four chained micro-rotations per cycle,
// streaming the direction decisions to the rotation units of the same QR row.
module gg_vectoring
   import gg_pkg::*;
#(
   parameter int R_LEN    = R_LEN_DEF,
   parameter int R_FRAC   = R_FRAC_DEF,
   parameter int ITER_CYC = ITER_CYC_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [R_LEN-1:0] xi,
   input  logic signed [R_LEN-1:0] yi,
   output logic                    d_valid,
   output logic        [3:0]       iter,
   output logic        [1:0]       d1,
   output logic        [1:0]       d2,
   output logic        [1:0]       d3,
   output logic        [1:0]       d4,
   output logic                    neg,
   output logic                    nop,
   output logic                    out_valid,
   output logic signed [R_LEN-1:0] xo,
   output logic signed [R_LEN-1:0] yo
);

   if (R_FRAC < 0 || R_FRAC >= R_LEN || 4*ITER_CYC-1 >= R_LEN || ITER_CYC < 1 || ITER_CYC > 4) begin : g_bad_param
      $error("gg_vectoring: illegal parameter combination");
   end

   state_e                  state_q, state_d;
   logic        [3:0]       cnt_q, cnt_d;
   logic signed [R_LEN-1:0] x_q, x_d, y_q, y_d;
   logic signed [R_LEN-1:0] xo_q, xo_d, yo_q, yo_d;
   logic        [3:0]       iter_q, iter_d;
   logic        [1:0]       d1_q, d1_d, d2_q, d2_d, d3_q, d3_d, d4_q, d4_d;
   logic                    d_valid_q, d_valid_d;
   logic                    out_valid_q, out_valid_d;
   logic                    neg_q, neg_d;
   logic                    nop_q, nop_d;

   logic signed [R_LEN-1:0] step_x, step_y;
   logic        [3:0]       base_shift;
   logic signed [R_LEN-1:0] cx [0:4];
   logic signed [R_LEN-1:0] cy [0:4];
   logic        [1:0]       cd [0:3];
   logic                    in_neg;
   logic                    last_cyc;

   assign cx[0]  = step_x;
   assign cy[0]  = step_y;
   assign in_neg = xi[R_LEN-1];

   for (genvar k = 0; k < 4; k++) begin : g_chain
      gg_micro_step #(.W(R_LEN)) u_step (
         .x_i   (cx[k]),
         .y_i   (cy[k]),
         .shift (base_shift + 4'(k)),
         .x_o   (cx[k+1]),
         .y_o   (cy[k+1]),
         .d_o   (cd[k])
      );
   end

   // The chain is fed from the (optionally negated) inputs while idle and from
   // the registered partial vector while rotating; results are registered alike.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      x_d         = x_q;
      y_d         = y_q;
      xo_d        = xo_q;
      yo_d        = yo_q;
      iter_d      = iter_q;
      d1_d        = d1_q;
      d2_d        = d2_q;
      d3_d        = d3_q;
      d4_d        = d4_q;
      nop_d       = nop_q;
      d_valid_d   = 1'b0;
      out_valid_d = 1'b0;
      neg_d       = 1'b0;
      step_x      = x_q;
      step_y      = y_q;
      base_shift  = {cnt_q[1:0], 2'b00};
      last_cyc    = 1'b0;

      case (state_q)
         IDLE: begin
            step_x     = in_neg ? -xi : xi;
            step_y     = in_neg ? -yi : yi;
            base_shift = 4'd0;
            last_cyc   = (ITER_CYC == 1);
            if (in_valid) begin
               neg_d     = in_neg;
               nop_d     = (yi == '0) && !in_neg;
               d_valid_d = 1'b1;
               state_d   = last_cyc ? IDLE : ROT;
               cnt_d     = last_cyc ? 4'd0 : 4'd1;
            end
         end
         ROT: begin
            last_cyc  = (cnt_q == 4'(ITER_CYC-1));
            d_valid_d = 1'b1;
            cnt_d     = last_cyc ? 4'd0 : cnt_q + 4'd1;
            state_d   = last_cyc ? IDLE : ROT;
         end
         default: state_d = IDLE;
      endcase

      if (d_valid_d) begin
         x_d    = cx[4];
         y_d    = cy[4];
         iter_d = base_shift;
         d1_d   = cd[0];
         d2_d   = cd[1];
         d3_d   = cd[2];
         d4_d   = cd[3];
         if (last_cyc) begin
            out_valid_d = 1'b1;
            xo_d        = cx[4];
            yo_d        = cy[4];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         x_q         <= '0;
         y_q         <= '0;
         xo_q        <= '0;
         yo_q        <= '0;
         iter_q      <= '0;
         d1_q        <= '0;
         d2_q        <= '0;
         d3_q        <= '0;
         d4_q        <= '0;
         d_valid_q   <= 1'b0;
         out_valid_q <= 1'b0;
         neg_q       <= 1'b0;
         nop_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         x_q         <= x_d;
         y_q         <= y_d;
         xo_q        <= xo_d;
         yo_q        <= yo_d;
         iter_q      <= iter_d;
         d1_q        <= d1_d;
         d2_q        <= d2_d;
         d3_q        <= d3_d;
         d4_q        <= d4_d;
         d_valid_q   <= d_valid_d;
         out_valid_q <= out_valid_d;
         neg_q       <= neg_d;
         nop_q       <= nop_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign d_valid   = d_valid_q;
   assign out_valid = out_valid_q;
   assign iter      = iter_q;
   assign d1        = d1_q;
   assign d2        = d2_q;
   assign d3        = d3_q;
   assign d4        = d4_q;
   assign neg       = neg_q;
   assign nop       = nop_q;
   assign xo        = xo_q;
   assign yo        = yo_q;

endmodule

// File: tb/tb_gg_vectoring.sv
// Randomized and directed bench for gg_vectoring against an integer CORDIC
// reference that tracks vector acceptance and the per-cycle decision stream.
module tb_gg_vectoring;

   localparam int R_LEN    = 12;
   localparam int ITER_CYC = 3;
   localparam int NSTEP    = 4 * ITER_CYC;

   logic                    clk;
   logic                    rst_n;
   logic                    in_valid;
   logic                    in_ready;
   logic signed [R_LEN-1:0] xi;
   logic signed [R_LEN-1:0] yi;
   logic                    d_valid;
   logic        [3:0]       iter;
   logic        [1:0]       d1, d2, d3, d4;
   logic                    neg;
   logic                    nop;
   logic                    out_valid;
   logic signed [R_LEN-1:0] xo;
   logic signed [R_LEN-1:0] yo;

   int checks   = 0;
   int failures = 0;

   bit mActive = 0;
   int mCyc    = 0;
   int mD [NSTEP];
   int mNeg, mNop, mXf, mYf;

   int firstNeg, firstNop, firstD1, firstD2, firstD3, firstD4;
   int lastXo, lastYo;

   gg_vectoring #(.R_LEN(R_LEN), .R_FRAC(2), .ITER_CYC(ITER_CYC)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .xi        (xi),
      .yi        (yi),
      .d_valid   (d_valid),
      .iter      (iter),
      .d1        (d1),
      .d2        (d2),
      .d3        (d3),
      .d4        (d4),
      .neg       (neg),
      .nop       (nop),
      .out_valid (out_valid),
      .xo        (xo),
      .yo        (yo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0d expected=%0d (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   function automatic int wrap(input int v);
      logic signed [R_LEN-1:0] t;
      t = v[R_LEN-1:0];
      return int'(t);
   endfunction

   // Full vector with plain integer arithmetic: sign fold, then 12 micro-rotations.
   task automatic modelVector(input int x0, input int y0);
      int x, y, nx, ny;
      mNeg = (x0 < 0) ? 1 : 0;
      mNop = (y0 == 0 && x0 >= 0) ? 1 : 0;
      x = mNeg ? wrap(-x0) : x0;
      y = mNeg ? wrap(-y0) : y0;
      for (int i = 0; i < NSTEP; i++) begin
         if (y == 0) begin
            mD[i] = 2;
         end else if (y > 0) begin
            nx = wrap(x + (y >>> i));
            ny = wrap(y - (x >>> i));
            x = nx; y = ny; mD[i] = 0;
         end else begin
            nx = wrap(x - (y >>> i));
            ny = wrap(y + (x >>> i));
            x = nx; y = ny; mD[i] = 1;
         end
      end
      mXf = x;
      mYf = y;
   endtask

   task automatic compareOutputs();
      bit lastCyc;
      lastCyc = mActive && (mCyc == ITER_CYC-1);
      checkOutput("d_valid", int'(d_valid), int'(mActive));
      checkOutput("in_ready", int'(in_ready), int'(!(mActive && mCyc < ITER_CYC-1)));
      checkOutput("out_valid", int'(out_valid), int'(lastCyc));
      if (mActive) begin
         checkOutput("iter", int'(iter), 4*mCyc);
         checkOutput("d1", int'(d1), mD[4*mCyc]);
         checkOutput("d2", int'(d2), mD[4*mCyc+1]);
         checkOutput("d3", int'(d3), mD[4*mCyc+2]);
         checkOutput("d4", int'(d4), mD[4*mCyc+3]);
         checkOutput("neg", int'(neg), (mCyc == 0) ? mNeg : 0);
         checkOutput("nop", int'(nop), mNop);
         if (mCyc == 0) begin
            firstNeg = int'(neg); firstNop = int'(nop);
            firstD1 = int'(d1); firstD2 = int'(d2); firstD3 = int'(d3); firstD4 = int'(d4);
         end
      end
      if (lastCyc) begin
         checkOutput("xo", int'(xo), mXf);
         checkOutput("yo", int'(yo), mYf);
         lastXo = int'(xo);
         lastYo = int'(yo);
      end
   endtask

   task automatic applyStimulus(input bit v, input int x, input int y);
      bit readyPre;
      @(negedge clk);
      in_valid = v;
      xi = x[R_LEN-1:0];
      yi = y[R_LEN-1:0];
      readyPre = !(mActive && mCyc < ITER_CYC-1);
      @(posedge clk);
      if (mActive) begin
         mCyc++;
         if (mCyc == ITER_CYC) mActive = 0;
      end
      if (readyPre && v) begin
         modelVector(x, y);
         mActive = 1;
         mCyc = 0;
      end
      #1;
      compareOutputs();
   endtask

   task automatic runVector(input int x, input int y);
      applyStimulus(1'b1, x, y);
      for (int i = 1; i < ITER_CYC; i++) applyStimulus(1'b0, 0, 0);
   endtask

   task automatic resetChecks(input string tag);
      checkOutput({tag, "_d_valid"}, int'(d_valid), 0);
      checkOutput({tag, "_out_valid"}, int'(out_valid), 0);
      checkOutput({tag, "_iter"}, int'(iter), 0);
      checkOutput({tag, "_d1d4"}, int'({d1, d2, d3, d4}), 0);
      checkOutput({tag, "_neg"}, int'(neg), 0);
      checkOutput({tag, "_nop"}, int'(nop), 0);
      checkOutput({tag, "_xo"}, int'(xo), 0);
      checkOutput({tag, "_yo"}, int'(yo), 0);
      checkOutput({tag, "_in_ready"}, int'(in_ready), 1);
   endtask

   function automatic int rnd();
      return int'($urandom_range(0, 1022)) - 511;
   endfunction

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0;
      xi = '0;
      yi = '0;
      repeat (2) @(posedge clk);
      #1;
      resetChecks("reset");
      @(negedge clk);
      rst_n = 1'b1;

      runVector(40, 0);
      checkOutput("nop_vec_nop", firstNop, 1);
      checkOutput("nop_vec_neg", firstNeg, 0);
      checkOutput("nop_vec_d", firstD1 + firstD2 + firstD3 + firstD4, 8);
      checkOutput("nop_vec_xo", lastXo, 40);
      checkOutput("nop_vec_yo", lastYo, 0);

      runVector(-40, 0);
      checkOutput("negx_neg", firstNeg, 1);
      checkOutput("negx_nop", firstNop, 0);
      checkOutput("negx_xo", lastXo, 40);
      checkOutput("negx_yo", lastYo, 0);

      runVector(40, 40);
      checkOutput("diag_d1", firstD1, 0);
      checkOutput("diag_d2", firstD2, 2);
      checkOutput("diag_xo", lastXo, 80);
      checkOutput("diag_yo", lastYo, 0);

      runVector(0, -20);
      checkOutput("negy_d", {firstD1, firstD2, firstD3, firstD4} == {1, 1, 1, 1} ? 1 : 0, 1);

      runVector(-2048, 5);
      applyStimulus(1'b0, 0, 0);

      for (int i = 0; i < 12; i++) applyStimulus(1'b1, rnd(), rnd());
      for (int i = 0; i < ITER_CYC; i++) applyStimulus(1'b0, 0, 0);

      applyStimulus(1'b1, 100, -50);
      applyStimulus(1'b0, 0, 0);
      #2;
      rst_n = 1'b0;
      mActive = 0;
      #1;
      resetChecks("midrst");
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < ITER_CYC + 1; i++) applyStimulus(1'b0, 0, 0);
      runVector(30, 70);
      applyStimulus(1'b0, 0, 0);

      for (int i = 0; i < 150; i++) begin
         int x, y;
         x = rnd();
         y = ($urandom_range(0, 7) == 0) ? 0 : rnd();
         applyStimulus($urandom_range(0, 3) != 0, x, y);
      end
      for (int i = 0; i < ITER_CYC; i++) applyStimulus(1'b0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
